// File: rtl/led_chaser_pkg.sv
// Shared types and constants for the LED fade chaser.
// Mode encoding, index width helper, default segment order.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_BLANK  = 2'b11
  } mode_e;

  localparam logic DECAY_EXP = 1'b0;
  localparam logic DECAY_LIN = 1'b1;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Figure-eight order a,b,g,e,d,c,g,f; position 0 in the low bits
  localparam logic [23:0] DEFAULT_SEQ_MAP = {
    3'd5, 3'd6, 3'd2, 3'd3,
    3'd4, 3'd6, 3'd1, 3'd0
  };

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with head/decay/blank control
// and a registered PWM comparison against the shared counter.
module led_pwm_channel
  import led_chaser_pkg::*;
#(
  parameter int BRIGHT_W = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                is_head,
  input  logic                decay_tick,
  input  logic                fade_lin,
  input  logic                blank,
  input  logic [BRIGHT_W-1:0] pwm_cnt,
  output logic                lit
);

  logic [BRIGHT_W-1:0] level;
  logic [BRIGHT_W-1:0] decayed;

  always_comb begin
    decayed = level >> 1;
    if (fade_lin == DECAY_LIN) begin
      decayed = (level == '0) ? '0 : level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      lit   <= 1'b0;
    end else begin
      lit <= (level != '0) && (level >= pwm_cnt);
      if (blank) begin
        level <= '0;
      end else if (is_head) begin
        level <= '1;
      end else if (decay_tick) begin
        level <= decayed;
      end
    end
  end

endmodule

// File: rtl/led_fade_chaser.sv
// Position chaser with per-channel PWM fade trails.
// Step timer, fade prescaler, pos/bounce FSM and output polarity.
module led_fade_chaser
  import led_chaser_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int BRIGHT_W   = 6,
  parameter int STEP_CNT_W = 24,
  parameter int SPEED_W    = 3,
  parameter int FADE_CNT_W = 21,
  parameter int SEQ_LEN    = 8,
  localparam int IDX_W     = idx_w(N_CH),
  parameter logic [SEQ_LEN*IDX_W-1:0] SEQ_MAP =
    DEFAULT_SEQ_MAP,
  parameter bit ACTIVE_LOW_OUT = 1'b1,
  localparam int POS_W     = idx_w(SEQ_LEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic               fade_lin,
  output logic [N_CH-1:0]    led_out,
  output logic [POS_W-1:0]   pos,
  output logic               step_pulse
);

  localparam int LOW_W = STEP_CNT_W - SPEED_W;
  localparam logic [POS_W-1:0] POS_MAX =
    POS_W'(SEQ_LEN - 1);

  logic [SPEED_W-1:0]    speed_r;
  logic                  dir_r;
  logic                  fade_r;
  mode_e                 mode_r;
  mode_e                 mode_q;

  logic [STEP_CNT_W-1:0] step_cnt;
  logic [STEP_CNT_W-1:0] limit;
  logic [FADE_CNT_W-1:0] fade_cnt;
  logic [BRIGHT_W-1:0]   pwm_cnt;
  logic                  step_due;
  logic                  moving;
  logic                  entering;
  logic                  bdir;
  logic                  bdir_eff;
  logic                  bdir_nx;
  logic [POS_W-1:0]      pos_nx;
  logic [IDX_W-1:0]      head_idx;
  logic [N_CH-1:0]       lit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_r <= '0;
      dir_r   <= 1'b0;
      fade_r  <= DECAY_EXP;
      mode_r  <= MODE_CHASE;
      mode_q  <= MODE_CHASE;
    end else begin
      speed_r <= speed;
      dir_r   <= dir;
      fade_r  <= fade_lin;
      mode_r  <= mode_e'(mode);
      mode_q  <= mode_r;
    end
  end

  assign limit    = {~speed_r, {LOW_W{1'b1}}};
  assign step_due = step_cnt >= limit;
  assign moving   = (mode_r == MODE_CHASE) ||
                    (mode_r == MODE_BOUNCE);
  assign entering = (mode_r == MODE_BOUNCE) &&
                    (mode_q != MODE_BOUNCE);
  assign bdir_eff = entering ? dir_r : bdir;

  // Bounce turns at the ends without repeating the end position
  always_comb begin
    pos_nx  = pos;
    bdir_nx = bdir_eff;
    unique case (mode_r)
      MODE_CHASE: begin
        if (dir_r) begin
          pos_nx = (pos == POS_MAX) ? '0 : pos + 1'b1;
        end else begin
          pos_nx = (pos == '0) ? POS_MAX : pos - 1'b1;
        end
      end
      MODE_BOUNCE: begin
        if (bdir_eff) begin
          if (pos == POS_MAX) begin
            pos_nx  = pos - 1'b1;
            bdir_nx = 1'b0;
          end else begin
            pos_nx  = pos + 1'b1;
          end
        end else begin
          if (pos == '0) begin
            pos_nx  = POS_W'(1);
            bdir_nx = 1'b1;
          end else begin
            pos_nx  = pos - 1'b1;
          end
        end
      end
      default: pos_nx = pos;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_cnt   <= '0;
      fade_cnt   <= '0;
      pwm_cnt    <= '0;
      step_pulse <= 1'b0;
      pos        <= '0;
      bdir       <= 1'b1;
    end else begin
      fade_cnt <= fade_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      bdir     <= bdir_eff;
      if (step_due) begin
        step_cnt   <= '0;
        step_pulse <= moving;
        pos        <= pos_nx;
        bdir       <= bdir_nx;
      end else begin
        step_cnt   <= step_cnt + 1'b1;
        step_pulse <= 1'b0;
      end
    end
  end

  assign head_idx = SEQ_MAP[int'(pos)*IDX_W +: IDX_W];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_pwm_channel #(
      .BRIGHT_W(BRIGHT_W)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .is_head   (head_idx == IDX_W'(i)),
      .decay_tick(&fade_cnt),
      .fade_lin  (fade_r),
      .blank     (mode_r == MODE_BLANK),
      .pwm_cnt   (pwm_cnt),
      .lit       (lit[i])
    );
  end

  assign led_out = lit ^ {N_CH{ACTIVE_LOW_OUT}};

endmodule

// File: tb/tb_led_fade_chaser.sv
// Directed bench for led_fade_chaser with short timers.
// Edges are counted from reset release; sampling is 1ns after posedge.
module tb_led_fade_chaser;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] speed = 3'd7;
  logic       dir = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       fade_lin = 1'b0;
  logic [7:0] led_out;
  logic [2:0] pos;
  logic       step_pulse;

  int errs = 0;
  int checks = 0;
  int ec = 0;

  led_fade_chaser #(
    .N_CH          (8),
    .BRIGHT_W      (6),
    .STEP_CNT_W    (6),
    .SPEED_W       (3),
    .FADE_CNT_W    (3),
    .SEQ_LEN       (8),
    .ACTIVE_LOW_OUT(1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .speed     (speed),
    .dir       (dir),
    .mode      (mode),
    .fade_lin  (fade_lin),
    .led_out   (led_out),
    .pos       (pos),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
    ec += n;
  endtask

  task automatic do_reset(input logic [2:0] sp,
                          input logic d,
                          input logic [1:0] m,
                          input logic fl);
    reset_n = 1'b0;
    speed = sp;
    dir = d;
    mode = m;
    fade_lin = fl;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ec = 0;
  endtask

  initial begin
    logic [31:0] pmask;
    logic        on_all;
    logic        pul_seen;
    int          lv_n[7];
    int          lv_e[7];
    int          hd[8];
    int          bseq[15];

    lv_n = '{15, 16, 24, 32, 40, 48, 56};
    lv_e = '{63, 31, 15, 7, 3, 1, 0};
    hd   = '{5, 6, 2, 3, 4, 6, 1, 0};
    bseq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    // Reset values and chase with exponential decay
    #1 reset_n = 1'b0;
    #2;
    chk("rst_led", led_out, 8'hFF);
    chk("rst_pos", pos, 0);
    chk("rst_pulse", step_pulse, 0);
    @(negedge clk);
    reset_n = 1'b1;
    ec = 0;

    cyc(1);
    chk("e1_led", led_out, 8'hFF);
    pmask = '0;
    pmask[1] = step_pulse;
    on_all = 1'b1;
    while (ec < 65) begin
      cyc(1);
      if (ec <= 24) pmask[ec] = step_pulse;
      if (ec <= 17) on_all &= ~led_out[0];
      for (int i = 0; i < 7; i++) begin
        if (ec == lv_n[i]) begin
          chk("exp_lvl0", dut.g_ch[0].u_ch.level, lv_e[i]);
        end
      end
      if (ec == 8) chk("pos_e8", pos, 1);
      if (ec == 32) chk("pwm_eq", led_out[1], 0);
      if (ec == 33) chk("pwm_below", led_out[1], 1);
      if (ec == 64) chk("pos_wrap", pos, 0);
      if (ec == 65) chk("zero_off", led_out[7], 1);
    end
    chk("pulse_mask", pmask, 32'h0101_0100);
    chk("ch0_full", on_all, 1);
    chk("relit_lvl0", dut.g_ch[0].u_ch.level, 63);

    // Linear decay and saturation at zero
    do_reset(3'd7, 1'b1, 2'b00, 1'b1);
    cyc(16);
    chk("lin_16", dut.g_ch[0].u_ch.level, 62);
    chk("lin_sat", dut.g_ch[7].u_ch.level, 0);
    cyc(8);
    chk("lin_24", dut.g_ch[0].u_ch.level, 61);
    cyc(8);
    chk("lin_32", dut.g_ch[0].u_ch.level, 60);

    // Chase downward through the default map
    do_reset(3'd7, 1'b0, 2'b00, 1'b0);
    cyc(8);
    for (int k = 1; k <= 8; k++) begin
      chk("dn_pos", pos, (8 - k) % 8);
      chk("dn_pulse", step_pulse, 1);
      cyc(2);
      chk("dn_head", led_out[hd[k-1]], 0);
      cyc(6);
    end

    // Bounce from position 0 upward
    do_reset(3'd7, 1'b1, 2'b01, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      cyc(8);
      chk("bn_pos", pos, bseq[k-1]);
      chk("bn_pulse", step_pulse, 1);
    end

    // Hold: pos frozen, head full, trail fades out
    mode = 2'b10;
    on_all = 1'b1;
    pul_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      pul_seen |= step_pulse;
      if (ec >= 122) on_all &= ~led_out[1];
    end
    chk("hold_pos", pos, 1);
    chk("hold_pulse", pul_seen, 0);
    chk("hold_head", on_all, 1);
    cyc(2);
    chk("hold_trail", led_out, 8'hFD);

    // Blank, then back to chase
    mode = 2'b11;
    cyc(1);
    chk("blk_e1", led_out, 8'hFD);
    cyc(2);
    chk("blk_off", led_out, 8'hFF);
    pul_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      pul_seen |= step_pulse;
    end
    chk("blk_pos", pos, 1);
    chk("blk_pulse", pul_seen, 0);
    chk("blk_led", led_out, 8'hFF);
    mode = 2'b00;
    cyc(2);
    chk("unblk_e1", led_out, 8'hFF);
    cyc(1);
    chk("unblk_head", led_out, 8'hFD);
    chk("unblk_pos", pos, 2);
    chk("unblk_pulse", step_pulse, 1);

    // Asynchronous reset in the middle of a trail
    cyc(5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_led", led_out, 8'hFF);
    chk("arst_pos", pos, 0);
    chk("arst_lvl6", dut.g_ch[6].u_ch.level, 0);
    chk("arst_lvl1", dut.g_ch[1].u_ch.level, 0);
    #10 reset_n = 1'b1;
    cyc(2);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/led_fade_chaser.md
Name: led_fade_chaser

Overview:
Parametrised segment/LED chaser with per-channel PWM fade trails. A configurable position sequence visits N_CH channels. The head channel is driven to full brightness. Every other channel decays, exponentially or linearly, and is rendered through a shared PWM counter. It sits behind the TinyTapeout io_in/io_out wrapper, driving a 7-segment display plus decimal point.

Parameters:
N_CH, 8, number of LED channels (2..16)
BRIGHT_W, 6, brightness level and PWM counter width
STEP_CNT_W, 24, step timer width
SPEED_W, 3, speed input width; occupies the top SPEED_W bits of the step limit
FADE_CNT_W, 21, decay tick prescaler width
SEQ_LEN, 8, number of positions in the sequence (2..16)
SEQ_MAP, {0,1,6,4,3,2,6,5}, packed SEQ_LEN x IDX_W channel indices; position p lights channel SEQ_MAP[p]
ACTIVE_LOW_OUT, 1, 1 = invert led_out (common anode)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
speed  in  SPEED_W  step rate; larger value = faster
dir  in  1  1 = increment position, 0 = decrement
mode  in  2  00 chase-wrap, 01 bounce, 10 hold, 11 blank
fade_lin  in  1  0 = exponential decay (>>1), 1 = linear decay (-1)
led_out  out  N_CH  PWM-modulated channel outputs, polarity per ACTIVE_LOW_OUT
pos  out  clog2(SEQ_LEN)  current sequence position
step_pulse  out  1  one-cycle pulse on each position step

Behaviour:
- Reset (async assert, sync release):
  - step_cnt=0, fade_cnt=0, pwm_cnt=0, pos=0, bdir=1.
  - All levels=0, step_pulse=0.
  - led_out all off: all ones if ACTIVE_LOW_OUT, else all zeros.
- Input sampling: speed, dir, mode and fade_lin each pass through one register stage. All logic below uses the registered copies.
- Step timer:
  - limit = {~speed_r, {STEP_CNT_W-SPEED_W{1'b1}}}.
  - If step_cnt >= limit: step_cnt<=0 and step_pulse<=1. Otherwise step_cnt increments and step_pulse<=0.
  - A limit that drops below step_cnt steps on the next cycle.
  - The timer runs in every mode. step_pulse is asserted only when pos actually changes.
- Position update on a step:
  - Chase mode: dir=1 gives pos+1, wrapping SEQ_LEN-1 -> 0. dir=0 gives pos-1, wrapping 0 -> SEQ_LEN-1.
  - Bounce mode: bdir is loaded from dir_r on the cycle mode_r becomes 01. Direction reverses at the ends, with no repeat of the end position: SEQ_LEN-1 moving up goes to SEQ_LEN-2 and sets bdir=0; 0 moving down goes to 1 and sets bdir=1.
  - Hold mode: pos is frozen. Levels keep their normal behaviour, so the head stays lit and the trail decays.
  - Blank mode: pos is frozen. All levels are forced to 0 every cycle.
- Levels (BRIGHT_W bits per channel):
  - A decay tick occurs the cycle fade_cnt wraps to 0; fade_cnt free-runs.
  - On a tick, each non-head channel decays: exponential gives L>>1; linear gives L-1, saturating at 0.
  - The head channel (SEQ_MAP[pos], using the current registered pos) is set to all ones every cycle. Head set has priority over decay.
  - The new head lights one cycle after pos changes. The old head starts decaying from that cycle.
  - A channel that appears multiple times in SEQ_MAP is lit whenever it is head. A SEQ_MAP entry >= N_CH lights nothing.
- PWM:
  - pwm_cnt is BRIGHT_W bits, free-running, wraps.
  - lit_i = (L_i != 0) && (L_i >= pwm_cnt). Level L is on for L+1 of every 2^BRIGHT_W cycles; L=0 is always off; max level is 100%.
  - led_out is registered: one cycle after the level/pwm_cnt state it reflects, XOR all ones if ACTIVE_LOW_OUT.
- Mode change mid-step: takes effect from the next step. Leaving blank resumes from the frozen pos, with the head relit the next cycle.
- reset_n asserted mid-operation: immediate return to reset values, independent of clk.

Decomposition:
- Package led_chaser_pkg holds:
  - the mode enum (MODE_CHASE, MODE_BOUNCE, MODE_HOLD, MODE_BLANK);
  - a clog2-based IDX_W helper;
  - DEFAULT_SEQ_MAP for the figure-eight 7-segment order;
  - the decay-select constants.
- Sub-module led_pwm_channel, instantiated N_CH times:
  - inputs: is_head, decay_tick, fade_lin, blank, pwm_cnt;
  - holds one level register and produces the registered lit bit.
- Top level holds the step timer, the fade prescaler, the pos/bdir FSM and the polarity.

Test Plan:
- Reset with STEP_CNT_W=6, SPEED_W=3, speed=7, ACTIVE_LOW_OUT=1 -> led_out=8'hFF; after release, step_pulse every 8 cycles (limit 7); channel 0 at 100% duty.
- Chase with dir=0 from pos=0 -> pos goes 0,7,6,...; SEQ_MAP default gives heads 0,5,6,2,3,4,6,1 in that order.
- Bounce with SEQ_LEN=8, dir=1, starting at pos 0 -> pos 0..7,6,5,...,0,1; each end visited once per reversal; step_pulse on every move.
- Exponential decay with BRIGHT_W=6, FADE_CNT_W=3 -> ex-head levels 63,31,15,7,3,1,0 on successive 8-cycle ticks; measured duty (L+1)/64 each period. Linear decay -> 63,62,...,0.
- Hold for 100 cycles -> pos unchanged, step_pulse stays 0, head 100%, others decay to 0. Blank -> all channels off within 2 cycles; return to chase -> head on the next cycle.
- reset_n pulsed low asynchronously mid-trail -> led_out all off immediately, pos=0, all levels 0.
